tx_sched: RTL and testbench

- Schedules the single UART transmitter between two 32-bit word requesters.
  - Sample readout path: captured samples streamed back after a run.
  - Command-response path: ID / metadata replies.
- Accepts one whole word at a time, serializes it LSB byte first, and skips sample bytes whose channel group is disabled.
- Sits between the capture controller / responder and the UART TX; a granted word is never pre-empted.

---
 rtl/tx_sched.sv | 134 +++++++++++++
 tb/tb_tx_sched.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_sched.sv
// rtl/tx_sched.sv - two-requester word-to-byte scheduler in front of the UART transmitter
// Optional feature: define TX_SCHED_RR_EN for round-robin tie break between requesters.
module tx_sched #(
   parameter int DW  = 32,
   parameter int GAP = 1
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      smp_stb_i,
   input  logic [DW-1:0]             smp_data_i,
   input  logic [DW/8-1:0]           grp_dis_i,
   output logic                      smp_rdy_o,
   input  logic                      rsp_stb_i,
   input  logic [DW-1:0]             rsp_data_i,
   input  logic [$clog2(DW/8)-1:0]   rsp_len_i,
   output logic                      rsp_rdy_o,
   input  logic                      tx_rdy_i,
   output logic [7:0]                tx_data_o,
   output logic                      tx_stb_o,
   output logic                      busy_o
);

   localparam int NB = DW / 8;
   localparam int IW = $clog2(NB);
   localparam int GW = $clog2(GAP + 1);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] sh_q;
   logic [NB-1:0] skip_q, rsp_skip;
   logic [IW-1:0] idx_q, last_q;
   logic [GW-1:0] gap_q;
   logic          grant_rsp, grant_smp;
   logic          accept, advance, is_last, gap_done;

`ifdef TX_SCHED_RR_EN
   logic prefer_rsp_q;

   // Whoever was not served by the latest accept wins the next tie.
   always_ff @(posedge clk_i) begin
      if (rst_i)
         prefer_rsp_q <= 1'b1;
      else if (accept)
         prefer_rsp_q <= grant_smp;
   end

   assign grant_rsp = rsp_stb_i & (~smp_stb_i | prefer_rsp_q);
   assign grant_smp = smp_stb_i & (~rsp_stb_i | ~prefer_rsp_q);
`else
   assign grant_rsp = rsp_stb_i;
   assign grant_smp = smp_stb_i & ~rsp_stb_i;
`endif

   assign is_last   = (idx_q == last_q);
   assign gap_done  = (gap_q == GW'(GAP - 1));
   assign busy_o    = (state_q != S_IDLE);
   assign tx_data_o = (state_q == S_IDLE) ? 8'h00 : sh_q[7:0];

   // Response bytes above the requested length are masked off at accept.
   always_comb begin
      rsp_skip = '0;
      for (int k = 0; k < NB; k++)
         rsp_skip[k] = (k > int'(rsp_len_i));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      tx_stb_o  = 1'b0;
      advance   = 1'b0;
      rsp_rdy_o = 1'b0;
      smp_rdy_o = 1'b0;
      case (state_q)
         S_IDLE: begin
            rsp_rdy_o = grant_rsp;
            smp_rdy_o = grant_smp;
            if (grant_rsp | grant_smp)
               state_d = S_SEND;
         end
         S_SEND: begin
            if (skip_q[0]) begin
               advance = 1'b1;
               state_d = is_last ? S_IDLE : S_SEND;
            end else if (tx_rdy_i) begin
               tx_stb_o = 1'b1;
               state_d  = S_GAP;
            end
         end
         S_GAP: begin
            if (gap_done) begin
               advance = 1'b1;
               state_d = is_last ? S_IDLE : S_SEND;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign accept = rsp_rdy_o | smp_rdy_o;

   // Current byte always sits in the low lane; data and skip mask shift together.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sh_q   <= '0;
         skip_q <= '0;
         idx_q  <= '0;
         last_q <= '0;
         gap_q  <= '0;
      end else begin
         if (accept) begin
            sh_q   <= grant_rsp ? rsp_data_i : smp_data_i;
            skip_q <= grant_rsp ? rsp_skip : grp_dis_i;
            last_q <= grant_rsp ? rsp_len_i : IW'(NB - 1);
            idx_q  <= '0;
         end else if (advance) begin
            sh_q   <= sh_q >> 8;
            skip_q <= skip_q >> 1;
            idx_q  <= idx_q + 1'b1;
         end
         if (state_q == S_GAP && !gap_done)
            gap_q <= gap_q + 1'b1;
         else
            gap_q <= '0;
      end
   end

endmodule

// File: tb/tb_tx_sched.sv
// tb/tb_tx_sched.sv - scoreboard bench for tx_sched
module tb_tx_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        smp_stb = 1'b0;
   logic [31:0] smp_data = '0;
   logic [3:0]  grp_dis = '0;
   logic        smp_rdy_o;
   logic        rsp_stb = 1'b0;
   logic [31:0] rsp_data = '0;
   logic [1:0]  rsp_len = '0;
   logic        rsp_rdy_o;
   logic        tx_rdy = 1'b1;
   logic [7:0]  tx_data_o;
   logic        tx_stb_o;
   logic        busy_o;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int busy_cnt = 0;
   int acc_cnt = 0;
   int acc_cyc = 0;
   logic [7:0] exp_q[$];
   logic       grant_q[$];
   int         stb_times[$];
   logic [7:0] exp_b;
   logic       exp_g, got_g;

   tx_sched #(.DW(32), .GAP(1)) dut (
      .clk_i(clk), .rst_i(rst),
      .smp_stb_i(smp_stb), .smp_data_i(smp_data), .grp_dis_i(grp_dis), .smp_rdy_o(smp_rdy_o),
      .rsp_stb_i(rsp_stb), .rsp_data_i(rsp_data), .rsp_len_i(rsp_len), .rsp_rdy_o(rsp_rdy_o),
      .tx_rdy_i(tx_rdy), .tx_data_o(tx_data_o), .tx_stb_o(tx_stb_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout cyc=%0d expected finish earlier", cyc);
      $fatal(1, "timeout");
   end

   // Monitor: pops expected bytes on strobes and expected grants on accepts.
   always @(negedge clk) begin
      cyc++;
      if (busy_o) busy_cnt++;
      if (!rst) begin
         if (tx_stb_o) begin
            checks++;
            stb_times.push_back(cyc);
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL stray_strobe data=%h expected no strobe", tx_data_o);
            end else begin
               exp_b = exp_q.pop_front();
               if (tx_data_o !== exp_b) begin
                  errors++;
                  $display("FAIL tx_byte got %h expected %h", tx_data_o, exp_b);
               end
            end
         end
         if ((rsp_stb & rsp_rdy_o) | (smp_stb & smp_rdy_o)) begin
            checks++;
            acc_cnt++;
            acc_cyc = cyc;
            got_g = rsp_stb & rsp_rdy_o;
            if (grant_q.size() == 0) begin
               errors++;
               $display("FAIL stray_accept rsp=%b expected no accept", got_g);
            end else begin
               exp_g = grant_q.pop_front();
               if (got_g !== exp_g || (rsp_rdy_o & smp_rdy_o)) begin
                  errors++;
                  $display("FAIL grant got rsp=%b smp_rdy=%b expected rsp=%b", got_g, smp_rdy_o, exp_g);
               end
            end
         end
      end
   end

   task automatic push_word(input logic [31:0] d, input logic [3:0] skip);
      for (int k = 0; k < 4; k++)
         if (!skip[k]) exp_q.push_back(d[k*8 +: 8]);
   endtask

   task automatic send_smp(input logic [31:0] d, input logic [3:0] dis);
      bit ok = 0;
      @(posedge clk); #1;
      smp_data = d; grp_dis = dis; smp_stb = 1'b1;
      push_word(d, dis);
      grant_q.push_back(1'b0);
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (smp_rdy_o) ok = 1;
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL smp_accept_timeout got none expected accept");
      end
      @(posedge clk); #1;
      smp_stb = 1'b0; smp_data = ~d; grp_dis = ~dis;
   endtask

   task automatic send_rsp(input logic [31:0] d, input logic [1:0] len);
      bit ok = 0;
      @(posedge clk); #1;
      rsp_data = d; rsp_len = len; rsp_stb = 1'b1;
      push_word(d, 4'b1110 << len);
      grant_q.push_back(1'b1);
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (rsp_rdy_o) ok = 1;
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL rsp_accept_timeout got none expected accept");
      end
      @(posedge clk); #1;
      rsp_stb = 1'b0; rsp_data = ~d; rsp_len = ~len;
   endtask

   task automatic wait_idle(input string name);
      bit ok = 0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (!busy_o && exp_q.size() == 0) ok = 1;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s idle_timeout busy=%b pending=%0d expected idle and 0", name, busy_o, exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks += 4;
      if (tx_stb_o !== 1'b0)  begin errors++; $display("FAIL reset_stb got %b expected 0", tx_stb_o); end
      if (tx_data_o !== 8'h00) begin errors++; $display("FAIL reset_data got %h expected 00", tx_data_o); end
      if (busy_o !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b expected 0", busy_o); end
      if ((rsp_rdy_o | smp_rdy_o) !== 1'b0) begin
         errors++; $display("FAIL reset_rdy got %b%b expected 00", rsp_rdy_o, smp_rdy_o);
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_single_sample();
      stb_times.delete();
      send_smp(32'h44332211, 4'b0000);
      wait_idle("single");
      checks++;
      if (stb_times.size() != 4) begin
         errors++; $display("FAIL single_count got %0d expected 4", stb_times.size());
      end else begin
         checks++;
         if (stb_times[0] - acc_cyc != 1) begin
            errors++; $display("FAIL first_latency got %0d expected 1", stb_times[0] - acc_cyc);
         end
         for (int i = 1; i < 4; i++) begin
            checks++;
            if (stb_times[i] - stb_times[i-1] != 2) begin
               errors++; $display("FAIL spacing got %0d expected 2", stb_times[i] - stb_times[i-1]);
            end
         end
      end
   endtask

   task automatic test_skip();
      stb_times.delete();
      send_smp(32'hDDCCBBAA, 4'b0101);
      wait_idle("skip_0101");
      checks++;
      if (stb_times.size() != 2) begin
         errors++; $display("FAIL skip_count got %0d expected 2", stb_times.size());
      end
      stb_times.delete();
      busy_cnt = 0;
      send_smp(32'h12345678, 4'b1111);
      wait_idle("skip_all");
      checks += 2;
      if (stb_times.size() != 0) begin
         errors++; $display("FAIL all_dis_count got %0d expected 0", stb_times.size());
      end
      if (busy_cnt != 4) begin
         errors++; $display("FAIL all_dis_busy got %0d expected 4", busy_cnt);
      end
   endtask

   task automatic test_priority();
      bit ok = 0;
      @(posedge clk); #1;
      rsp_data = 32'h534C4131; rsp_len = 2'd3; rsp_stb = 1'b1;
      smp_data = 32'h0D0C0B0A; grp_dis = 4'b0000; smp_stb = 1'b1;
      grant_q.push_back(1'b1); push_word(32'h534C4131, 4'b0000);
      grant_q.push_back(1'b0); push_word(32'h0D0C0B0A, 4'b0000);
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (rsp_rdy_o) ok = 1;
      end
      @(posedge clk); #1;
      rsp_stb = 1'b0; rsp_data = '0;
      ok = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (!busy_o) ok = 1;
      end
      checks++;
      if (!ok || smp_rdy_o !== 1'b1) begin
         errors++; $display("FAIL smp_after_rsp got rdy=%b expected 1", smp_rdy_o);
      end
      @(posedge clk); #1;
      smp_stb = 1'b0; grp_dis = 4'b1111;
      wait_idle("priority");
      stb_times.delete();
      send_rsp(32'h000000A5, 2'd0);
      wait_idle("rsp_len0");
      checks++;
      if (stb_times.size() != 1) begin
         errors++; $display("FAIL rsp_len0_count got %0d expected 1", stb_times.size());
      end
   endtask

   task automatic test_tx_stall();
      bit ok = 0;
      tx_rdy = 1'b0;
      stb_times.delete();
      send_smp(32'h87654321, 4'b0000);
      for (int i = 0; i < 20 && !ok; i++) begin
         if (busy_o) ok = 1; else @(negedge clk);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks += 2;
         if (tx_stb_o !== 1'b0) begin errors++; $display("FAIL stall_stb got %b expected 0", tx_stb_o); end
         if (tx_data_o !== 8'h21) begin errors++; $display("FAIL stall_data got %h expected 21", tx_data_o); end
      end
      @(posedge clk); #1;
      tx_rdy = 1'b1;
      @(negedge clk);
      checks++;
      if (tx_stb_o !== 1'b1) begin errors++; $display("FAIL stall_release got %b expected 1", tx_stb_o); end
      wait_idle("stall");
   endtask

   task automatic test_reset_mid();
      bit ok = 0;
      stb_times.delete();
      send_smp(32'h04030201, 4'b0000);
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (stb_times.size() >= 2) ok = 1;
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      checks += 3;
      if (tx_stb_o !== 1'b0)   begin errors++; $display("FAIL midrst_stb got %b expected 0", tx_stb_o); end
      if (tx_data_o !== 8'h00) begin errors++; $display("FAIL midrst_data got %h expected 00", tx_data_o); end
      if (busy_o !== 1'b0)     begin errors++; $display("FAIL midrst_busy got %b expected 0", busy_o); end
      repeat (10) @(negedge clk);
      checks++;
      if (stb_times.size() != 2) begin
         errors++; $display("FAIL midrst_strobes got %0d expected 2", stb_times.size());
      end
      stb_times.delete();
      send_smp(32'hCAFEF00D, 4'b0000);
      wait_idle("after_reset");
      checks++;
      if (stb_times.size() != 4) begin
         errors++; $display("FAIL after_reset_count got %0d expected 4", stb_times.size());
      end
   endtask

   task automatic test_back_to_back();
      int a0;
      bit g;
      @(posedge clk); #1;
      rsp_data = 32'h0000005A; rsp_len = 2'd0; rsp_stb = 1'b1;
      smp_data = 32'h000000C3; grp_dis = 4'b1110; smp_stb = 1'b1;
      for (int i = 0; i < 4; i++) begin
`ifdef TX_SCHED_RR_EN
         g = (i % 2 == 0);
`else
         g = 1'b1;
`endif
         grant_q.push_back(g);
         exp_q.push_back(g ? 8'h5A : 8'hC3);
      end
      a0 = acc_cnt;
      for (int i = 0; i < 300 && (acc_cnt - a0) < 4; i++)
         @(negedge clk);
      @(posedge clk); #1;
      rsp_stb = 1'b0; smp_stb = 1'b0;
      wait_idle("back_to_back");
      checks++;
      if (acc_cnt - a0 != 4) begin
         errors++; $display("FAIL b2b_accepts got %0d expected 4", acc_cnt - a0);
      end
   endtask

   initial begin
      test_reset();
      test_single_sample();
      test_skip();
      test_priority();
      test_tx_stall();
      test_reset_mid();
      test_back_to_back();
      repeat (5) @(negedge clk);
      checks += 2;
      if (exp_q.size() != 0) begin errors++; $display("FAIL bytes_left got %0d expected 0", exp_q.size()); end
      if (grant_q.size() != 0) begin errors++; $display("FAIL grants_left got %0d expected 0", grant_q.size()); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
